// File: rtl/bp_me_cce_id_to_addr_gen.sv
// Sweeps a block-aligned DRAM region and emits, in ascending order, every
// cache-block address whose block index maps to the given CCE (index mod num_cce_p).
module bp_me_cce_id_to_addr_gen #(
    parameter int paddr_width_p     = 40,
    parameter int num_cce_p         = 4,
    parameter int cce_block_width_p = 512,
    parameter int count_width_p     = 32,
    localparam int cce_id_width_lp  = (num_cce_p > 1) ? $clog2(num_cce_p) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    output logic                       ready_o,
    input  logic                       start_i,
    input  logic [cce_id_width_lp-1:0] cce_id_i,
    input  logic [paddr_width_p-1:0]   base_paddr_i,
    input  logic [count_width_p-1:0]   num_blocks_i,
    output logic                       addr_v_o,
    output logic [paddr_width_p-1:0]   addr_o,
    input  logic                       addr_ready_and_i,
    output logic                       done_o
);

    localparam int block_offset_lp = $clog2(cce_block_width_p/8);
    localparam int bidx_w_lp       = paddr_width_p - block_offset_lp;
    // One extra bit so sums past the top block index are visible as overflow
    localparam int ext_w_lp        = bidx_w_lp + 1;
    localparam logic [ext_w_lp-1:0] cce_mask_lp = ext_w_lp'(num_cce_p - 1);
    localparam logic [ext_w_lp-1:0] cce_step_lp = ext_w_lp'(num_cce_p);

    typedef enum logic [1:0] {IDLE, INIT, EMIT, DONE} state_e;

    state_e                     state_q, state_d;
    logic [cce_id_width_lp-1:0] cce_id_q, cce_id_d;
    logic [ext_w_lp-1:0]        b0_q, b0_d;
    logic [count_width_p-1:0]   num_blocks_q, num_blocks_d;
    logic [ext_w_lp-1:0]        cur_q, cur_d;
    logic [ext_w_lp-1:0]        end_q, end_d;

    logic [ext_w_lp-1:0] first_idx, end_idx, next_idx;
    logic                unused_base_bits;

    assign unused_base_bits = ^base_paddr_i[block_offset_lp-1:0];

    // Masking with num_cce_p-1 is the modulo because num_cce_p is a power of two
    assign first_idx = b0_q + ((ext_w_lp'(cce_id_q) - b0_q) & cce_mask_lp);
    assign end_idx   = b0_q + ext_w_lp'(num_blocks_q);
    assign next_idx  = cur_q + cce_step_lp;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            cce_id_q     <= '0;
            b0_q         <= '0;
            num_blocks_q <= '0;
            cur_q        <= '0;
            end_q        <= '0;
        end else begin
            state_q      <= state_d;
            cce_id_q     <= cce_id_d;
            b0_q         <= b0_d;
            num_blocks_q <= num_blocks_d;
            cur_q        <= cur_d;
            end_q        <= end_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cce_id_d     = cce_id_q;
        b0_d         = b0_q;
        num_blocks_d = num_blocks_q;
        cur_d        = cur_q;
        end_d        = end_q;
        ready_o      = 1'b0;
        addr_v_o     = 1'b0;
        addr_o       = '0;
        done_o       = 1'b0;

        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    cce_id_d     = cce_id_i;
                    b0_d         = ext_w_lp'(base_paddr_i[paddr_width_p-1:block_offset_lp]);
                    num_blocks_d = num_blocks_i;
                    state_d      = INIT;
                end
            end
            INIT: begin
                end_d = end_idx;
                if ((first_idx >= end_idx) || first_idx[bidx_w_lp]) begin
                    state_d = DONE;
                end else begin
                    cur_d   = first_idx;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                addr_v_o = 1'b1;
                addr_o   = {cur_q[bidx_w_lp-1:0], {block_offset_lp{1'b0}}};
                if (addr_ready_and_i) begin
                    if ((next_idx >= end_q) || next_idx[bidx_w_lp]) begin
                        state_d = DONE;
                    end else begin
                        cur_d = next_idx;
                    end
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bp_me_cce_id_to_addr_gen.sv
// Scoreboard bench for bp_me_cce_id_to_addr_gen: a reference model queues the owned
// addresses for each sweep and the monitor loop pops them as transfers happen.
module tb_bp_me_cce_id_to_addr_gen;

    localparam longint MAXB = (64'd1 << 34) - 1;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        ready_o;
    logic        start_i;
    logic [1:0]  cce_id_i;
    logic [39:0] base_paddr_i;
    logic [31:0] num_blocks_i;
    logic        addr_v_o;
    logic [39:0] addr_o;
    logic        addr_ready_and_i;
    logic        done_o;

    int tests = 0;
    int fails = 0;
    logic [39:0] exp_q[$];

    bp_me_cce_id_to_addr_gen dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .ready_o         (ready_o),
        .start_i         (start_i),
        .cce_id_i        (cce_id_i),
        .base_paddr_i    (base_paddr_i),
        .num_blocks_i    (num_blocks_i),
        .addr_v_o        (addr_v_o),
        .addr_o          (addr_o),
        .addr_ready_and_i(addr_ready_and_i),
        .done_o          (done_o)
    );

    always #5 clk = ~clk;

    task automatic push_model(input logic [39:0] base, input int nb, input int id);
        longint b0;
        b0 = longint'(base >> 6);
        for (longint b = b0; b < b0 + nb; b++)
            if ((b % 4) == id && b <= MAXB) exp_q.push_back(40'(b << 6));
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        start_i = 1'b0;
        cce_id_i = '0;
        base_paddr_i = '0;
        num_blocks_i = '0;
        addr_ready_and_i = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b want=1", ready_o); end
        tests++; if (addr_v_o !== 1'b0) begin fails++; $display("FAIL reset_addr_v got=%b want=0", addr_v_o); end
        tests++; if (addr_o !== 40'h0) begin fails++; $display("FAIL reset_addr got=%h want=0", addr_o); end
        tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL reset_done got=%b want=0", done_o); end
        reset_i = 1'b0;
        @(negedge clk);
    endtask

    // Runs one sweep; stall_len holds addr_ready_and_i low for that many valid
    // cycles starting at the first valid; abort asserts reset mid-stall.
    task automatic run_sweep(input string nm, input logic [39:0] base, input int nb,
                             input int id, input int stall_len, input bit abort);
        int n_exp, first_v, last_x, done_cyc, stall_cnt;
        bit stall;
        exp_q.delete();
        push_model(base, nb, id);
        n_exp = exp_q.size();
        first_v = -1; last_x = -1; done_cyc = -1; stall_cnt = 0;

        @(negedge clk);
        tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL %s ready_before_start got=%b want=1", nm, ready_o); end
        start_i = 1'b1; base_paddr_i = base; num_blocks_i = 32'(nb); cce_id_i = 2'(id);
        addr_ready_and_i = 1'b1;

        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (cyc == 1) begin
                tests++;
                if (ready_o !== 1'b0 || addr_v_o !== 1'b0 || done_o !== 1'b0) begin
                    fails++; $display("FAIL %s init_cycle got ready=%b v=%b done=%b want 0/0/0", nm, ready_o, addr_v_o, done_o);
                end
            end
            if (addr_v_o === 1'b1) begin
                if (first_v < 0) first_v = cyc;
                stall = (stall_cnt < stall_len);
                addr_ready_and_i = !stall;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL %s extra_addr got=%h want=none", nm, addr_o);
                end else if (addr_o !== exp_q[0]) begin
                    fails++; $display("FAIL %s addr got=%h want=%h", nm, addr_o, exp_q[0]);
                end
                if (stall) begin
                    stall_cnt++;
                    if (stall_cnt == 2) begin
                        start_i = 1'b1; base_paddr_i = 40'h0; cce_id_i = 2'd0; num_blocks_i = 32'd100;
                    end
                    if (abort && stall_cnt == 3) begin
                        #2 reset_i = 1'b1;
                        #1;
                        tests++;
                        if (addr_v_o !== 1'b0 || addr_o !== 40'h0 || done_o !== 1'b0 || ready_o !== 1'b1) begin
                            fails++; $display("FAIL %s async_reset got v=%b addr=%h done=%b ready=%b want 0/0/0/1", nm, addr_v_o, addr_o, done_o, ready_o);
                        end
                        @(negedge clk);
                        reset_i = 1'b0;
                        addr_ready_and_i = 1'b1;
                        @(negedge clk);
                        tests++;
                        if (ready_o !== 1'b1 || done_o !== 1'b0 || addr_v_o !== 1'b0) begin
                            fails++; $display("FAIL %s after_reset got ready=%b done=%b v=%b want 1/0/0", nm, ready_o, done_o, addr_v_o);
                        end
                        exp_q.delete();
                        return;
                    end
                end else if (exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    last_x = cyc;
                end
            end else begin
                addr_ready_and_i = 1'b1;
                if (first_v >= 0 && exp_q.size() > 0) begin
                    tests++;
                    fails++; $display("FAIL %s valid_dropped got v=%b want=1", nm, addr_v_o);
                end
            end
            if (done_o === 1'b1) begin
                done_cyc = cyc;
                break;
            end
        end

        tests++; if (done_cyc < 0) begin fails++; $display("FAIL %s done_timeout got=none want=pulse", nm); end
        tests++;
        if (done_cyc != ((n_exp > 0) ? last_x + 1 : 2)) begin
            fails++; $display("FAIL %s done_cycle got=%0d want=%0d", nm, done_cyc, (n_exp > 0) ? last_x + 1 : 2);
        end
        tests++;
        if (first_v != ((n_exp > 0) ? 2 : -1)) begin
            fails++; $display("FAIL %s first_valid_cycle got=%0d want=%0d", nm, first_v, (n_exp > 0) ? 2 : -1);
        end
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL %s missing_addrs got=%0d left want=0", nm, exp_q.size()); end
        @(negedge clk);
        tests++;
        if (done_o !== 1'b0 || ready_o !== 1'b1) begin
            fails++; $display("FAIL %s post_done got done=%b ready=%b want 0/1", nm, done_o, ready_o);
        end
    endtask

    task automatic test_basic();
        run_sweep("basic", 40'h00_8000_0000, 8, 1, 0, 1'b0);
        run_sweep("unaligned_base", 40'h00_8000_00C0, 2, 0, 0, 1'b0);
        run_sweep("low_bits_ignored", 40'h00_8000_00FF, 9, 2, 0, 1'b0);
    endtask

    task automatic test_empty();
        run_sweep("empty", 40'h00_8000_0000, 0, 2, 0, 1'b0);
    endtask

    task automatic test_stall();
        run_sweep("stall", 40'h00_8000_0000, 8, 1, 5, 1'b0);
    endtask

    task automatic test_reset_mid_sweep();
        run_sweep("abort", 40'h00_8000_0000, 8, 1, 5, 1'b1);
        run_sweep("rerun", 40'h00_8000_0000, 8, 1, 0, 1'b0);
    endtask

    task automatic test_overflow();
        run_sweep("overflow", 40'hFF_FFFF_FFC0, 4, 3, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_sweep("b2b_a", 40'h00_1234_5600, 13, 0, 0, 1'b0);
        run_sweep("b2b_b", 40'h00_1234_5640, 7, 3, 2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_stall();
        test_reset_mid_sweep();
        test_overflow();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
